// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: decodes the immediate format from the opcode,
// extends it to XLEN, adds it to the PC, and registers the result behind a 2-entry skid.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            ill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
  } res_t;

  logic [6:0]         w_op;
  logic [2:0]         w_f3;
  fmt_e               w_fmt;
  logic               w_ill;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;
  logic               w_acc;
  res_t               w_res;

  res_t r_m, r_k;
  logic r_m_vld, r_k_vld;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];

  always_comb begin
    w_fmt = FMT_NONE;
    w_ill = 1'b0;
    case (w_op)
      7'b0000011, 7'b1100111, 7'b0001111: w_fmt = FMT_I;
      7'b0010011: w_fmt = (w_f3 == 3'b001 || w_f3 == 3'b101) ? FMT_SHAMT : FMT_I;
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b0110111, 7'b0010111: w_fmt = FMT_U;
      7'b1101111: w_fmt = FMT_J;
      7'b1110011: w_fmt = (w_f3[2] && ZIMM_EN) ? FMT_ZIMM : FMT_I;
      7'b0110011: w_fmt = FMT_NONE;
      // Every legal opcode ends in 2'b11, so a bad low pair lands here too
      default:    w_ill = 1'b1;
    endcase
  end

  // SHAMT and ZIMM are built with a clear top bit, so one sign-extension serves all formats
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I:     w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_SHAMT: w_imm32 = {26'b0, (XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]};
      FMT_S:     w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:     w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:     w_imm32 = {in_instr[31:12], 12'b0};
      FMT_J:     w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
      FMT_ZIMM:  w_imm32 = {27'b0, in_instr[19:15]};
      default:   w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'(w_imm32);

  assign w_res.imm = w_imm;
  assign w_res.fmt = w_fmt;
  assign w_res.ill = w_ill;
  assign w_res.pc  = in_pc;
  assign w_res.tgt = in_pc + w_imm;

  assign in_ready = !r_k_vld;
  assign w_acc    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m     <= '0;
      r_k     <= '0;
      r_m_vld <= 1'b0;
      r_k_vld <= 1'b0;
    end else if (flush) begin
      r_m_vld <= 1'b0;
      r_k_vld <= 1'b0;
    end else if (!r_m_vld || out_ready) begin
      if (r_k_vld) begin
        r_m     <= r_k;
        r_m_vld <= 1'b1;
        r_k_vld <= w_acc;
        if (w_acc) r_k <= w_res;
      end else if (w_acc) begin
        r_m     <= w_res;
        r_m_vld <= 1'b1;
      end else begin
        r_m_vld <= 1'b0;
      end
    end else if (w_acc) begin
      r_k     <= w_res;
      r_k_vld <= 1'b1;
    end
  end

  assign out_valid   = r_m_vld;
  assign out_imm     = r_m.imm;
  assign out_fmt     = r_m.fmt;
  assign out_illegal = r_m.ill;
  assign out_pc      = r_m.pc;
  assign out_target  = r_m.tgt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit (ZIMM on) and a 64-bit (ZIMM off) instance share
// one input stream and are checked against a field-arithmetic reference and a FIFO model.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, pc32, tgt32;
  logic [2:0]  fmt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, pc64, tgt64;
  logic [2:0]  fmt64;

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b1)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_pc(pc32), .out_target(tgt32));

  imm_gen_pipe #(.XLEN(64), .ZIMM_EN(1'b0)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_pc(pc64), .out_target(tgt64));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference immediate from the ISA field rules, using integer arithmetic
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen,
                                          input bit zen, output logic [2:0] fmt,
                                          output bit ill);
    longint v;
    logic [2:0] f3;
    f3 = ins[14:12];
    fmt = 3'd0; ill = 1'b0; v = 0;
    case (ins[6:0])
      7'h03, 7'h67, 7'h0F: fmt = 3'd1;
      7'h13: fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd2 : 3'd1;
      7'h23: fmt = 3'd3;
      7'h63: fmt = 3'd4;
      7'h37, 7'h17: fmt = 3'd5;
      7'h6F: fmt = 3'd6;
      7'h73: fmt = (f3[2] && zen) ? 3'd7 : 3'd1;
      7'h33: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
    case (fmt)
      3'd1: v = longint'($signed(ins[31:20]));
      3'd2: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd3: v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd4: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      3'd5: v = longint'($signed(ins[31:12])) * 4096;
      3'd6: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      3'd7: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic chk_out(input item_t it);
    logic [63:0] e;
    logic [2:0]  f;
    bit          il;
    e = ref_imm(it.ins, 32, 1'b1, f, il);
    chk("imm32", {32'b0, imm32}, e);
    chk("fmt32", {61'b0, fmt32}, {61'b0, f});
    chk("ill32", {63'b0, ill32}, {63'b0, il});
    chk("pc32", {32'b0, pc32}, {32'b0, it.pc[31:0]});
    chk("tgt32", {32'b0, tgt32}, (e + it.pc) & 64'h0000_0000_FFFF_FFFF);
    e = ref_imm(it.ins, 64, 1'b0, f, il);
    chk("imm64", imm64, e);
    chk("fmt64", {61'b0, fmt64}, {61'b0, f});
    chk("ill64", {63'b0, ill64}, {63'b0, il});
    chk("pc64", pc64, it.pc);
    chk("tgt64", tgt64, e + it.pc);
  endtask

  // Called just after a falling edge with inputs already driven; ends at the next falling edge
  task automatic tick();
    bit acc, fire;
    item_t it;
    #1;
    chk("in_ready32", {63'b0, rdy32}, {63'b0, q.size() < 2});
    chk("in_ready64", {63'b0, rdy64}, {63'b0, q.size() < 2});
    chk("out_valid32", {63'b0, ov32}, {63'b0, q.size() > 0});
    chk("out_valid64", {63'b0, ov64}, {63'b0, q.size() > 0});
    if (q.size() > 0) chk_out(q[0]);
    acc  = in_valid && (q.size() < 2);
    fire = out_ready && (q.size() > 0);
    it.ins = in_instr;
    it.pc  = in_pc;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic chk_empty_zero(input string tag);
    chk({tag, "_ov"}, {63'b0, ov32 | ov64}, 64'd0);
    chk({tag, "_rdy"}, {62'b0, rdy32, rdy64}, 64'd3);
    chk({tag, "_imm"}, imm64 | {32'b0, imm32}, 64'd0);
    chk({tag, "_fmt"}, {58'b0, fmt32, fmt64}, 64'd0);
    chk({tag, "_ill"}, {62'b0, ill32, ill64}, 64'd0);
    chk({tag, "_pc"}, pc64 | {32'b0, pc32}, 64'd0);
    chk({tag, "_tgt"}, tgt64 | {32'b0, tgt32}, 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(negedge clk); @(negedge clk);
    chk_empty_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed decode cases
    send(32'hFFF00093, 64'h100);
    chk("addi_imm32", {32'b0, imm32}, 64'hFFFF_FFFF);
    chk("addi_fmt", {61'b0, fmt32}, 64'd1);
    chk("addi_tgt32", {32'b0, tgt32}, 64'hFF);
    chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_tgt64", tgt64, 64'hFF);
    send(32'h41F0D093, 64'h0);
    chk("srai_imm32", {32'b0, imm32}, 64'h1F);
    chk("srai_fmt", {61'b0, fmt32}, 64'd2);
    send(32'h43F0D093, 64'h0);
    chk("srai63_imm64", imm64, 64'h3F);
    chk("srai63_imm32", {32'b0, imm32}, 64'h1F);
    send(32'hFE000EE3, 64'h200);
    chk("beq_imm32", {32'b0, imm32}, 64'hFFFF_FFFC);
    chk("beq_fmt", {61'b0, fmt32}, 64'd4);
    chk("beq_tgt32", {32'b0, tgt32}, 64'h1FC);
    send(32'h0010006F, 64'h0);
    chk("jal_imm32", {32'b0, imm32}, 64'h800);
    chk("jal_fmt", {61'b0, fmt32}, 64'd6);
    send(32'h800000B7, 64'h0);
    chk("lui_imm32", {32'b0, imm32}, 64'h8000_0000);
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    send(32'h340FD073, 64'h0);
    chk("csrrwi_imm32", {32'b0, imm32}, 64'h1F);
    chk("csrrwi_fmt32", {61'b0, fmt32}, 64'd7);
    chk("csrrwi_fmt64_nozimm", {61'b0, fmt64}, 64'd1);
    chk("csrrwi_imm64_nozimm", imm64, 64'h340);
    send(32'h0000007F, 64'h0);
    chk("ill_flag", {63'b0, ill32}, 64'd1);
    chk("ill_imm", {32'b0, imm32}, 64'd0);
    send(32'h00000090, 64'h0);
    chk("lowbits_ill", {63'b0, ill64}, 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Back-pressure: three words presented with the consumer stalled
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; in_pc = 64'h10; tick();
    in_instr = 32'h00200093; in_pc = 64'h14; tick();
    in_instr = 32'h00300093; in_pc = 64'h18;
    #1;
    chk("stall_in_ready", {63'b0, rdy32}, 64'd0);
    tick(); tick();
    out_ready = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("drain_empty", {63'b0, ov32}, 64'd0);

    // Flush with both entries full and a word presented in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00400093; in_pc = 64'h20; tick();
    in_instr = 32'h00500093; in_pc = 64'h24; tick();
    flush = 1'b1; in_instr = 32'h00600093; in_pc = 64'h28;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_ov", {63'b0, ov32}, 64'd0);
    chk("flush_rdy", {63'b0, rdy32}, 64'd1);
    out_ready = 1'b1;
    tick(); tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00700093; in_pc = 64'h30; tick();
    in_instr = 32'h00800093; in_pc = 64'h34; tick();
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk_empty_zero("midrst");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    // Randomised traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom, $urandom};
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
